// File: rtl/mux_rr_feeder_if.sv
// Handshake bundle between the four request sources, the feeder and the
// downstream consumer of the captured word.
//   req/a/b/c/d : source requests and per-channel data
//   ack         : one-hot capture pulse back to the sources
//   sel         : select of the last granted channel (drives the data mux)
//   out_data/out_valid/out_ready : downstream valid/ready channel
// The slave modport is the feeder's view; master is the environment's view.
interface mux_rr_feeder_if #(
    parameter int DW = 4
) ();
    logic [3:0]    req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [3:0]    ack;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport slave (
        input  req, a, b, c, d, out_ready,
        output ack, sel, out_data, out_valid
    );

    modport master (
        output req, a, b, c, d, out_ready,
        input  ack, sel, out_data, out_valid
    );
endinterface

// File: rtl/mux_rr_feeder.sv
// Round-robin feeder for the 4-to-1 data mux. Picks one of four requesting
// sources, captures its word into an output register, drives the mux select
// and hands the word downstream over valid/ready.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_feeder_if.slave (req, a..d, ack, sel, out_*)
//
// state | meaning
// IDLE  | output register empty, out_valid=0
// FULL  | output register holds a word, out_valid=1
module mux_rr_feeder #(
    parameter int DW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_rr_feeder_if.slave bus
);

    typedef enum logic {IDLE, FULL} state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    ptr_d;
    logic [3:0]    ack_q;
    logic [1:0]    sel_q;
    logic [DW-1:0] data_q;
    logic          valid_q;

    logic [3:0]    ereq;
    logic          win_found;
    logic [1:0]    win_idx;
    logic [DW-1:0] win_data;

    // A source keeps req high in the cycle its ack is visible, so mask it
    // to avoid granting the same word twice.
    assign ereq = bus.req & ~ack_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            automatic logic [1:0] idx = ptr_q + 2'(i);
            if (!win_found && ereq[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        case (win_idx)
            2'd0:    win_data = bus.a;
            2'd1:    win_data = bus.b;
            2'd2:    win_data = bus.c;
            default: win_data = bus.d;
        endcase
    end

    assign ptr_d = win_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            ack_q   <= 4'b0000;
            sel_q   <= 2'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        sel_q   <= win_idx;
                        data_q  <= win_data;
                        valid_q <= 1'b1;
                        ack_q   <= 4'b0001 << win_idx;
                        ptr_q   <= ptr_d;
                        state_q <= FULL;
                    end else begin
                        ack_q <= 4'b0000;
                    end
                end
                FULL: begin
                    if (!bus.out_ready) begin
                        ack_q <= 4'b0000;
                    end else if (win_found) begin
                        // accept and reload on the same edge: no bubble
                        sel_q   <= win_idx;
                        data_q  <= win_data;
                        ack_q   <= 4'b0001 << win_idx;
                        ptr_q   <= ptr_d;
                    end else begin
                        // sel/data keep their last values so the mux is quiet
                        valid_q <= 1'b0;
                        ack_q   <= 4'b0000;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ack_q   <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_feeder.sv
module tb_mux_rr_feeder;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nchecks;
    int   nerrors;
    exp_t sb_q[$];

    mux_rr_feeder_if #(.DW(4)) bus ();

    mux_rr_feeder #(.DW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", nchecks, nerrors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.a = 4'h0; bus.b = 4'h0; bus.c = 4'h0; bus.d = 4'h0;
        bus.out_ready = 1'b0;
        tick(); tick();
        nchecks++;
        if ({bus.ack, bus.sel, bus.out_data, bus.out_valid} !== 11'd0) begin
            nerrors++;
            $display("FAIL reset_outputs: ack=%b sel=%0d data=%h valid=%b, required all zero",
                     bus.ack, bus.sel, bus.out_data, bus.out_valid);
        end
        rst_n = 1'b1;
        tick(); tick();
        nchecks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
            nerrors++;
            $display("FAIL reset_idle: valid=%b ack=%b, required 0/0000", bus.out_valid, bus.ack);
        end
    endtask

    task automatic test_single();
        exp_t e;
        bus.req = 4'b0100; bus.c = 4'hA; bus.out_ready = 1'b1;
        sb_q.push_back('{ch: 2'd2, data: 4'hA});
        tick();
        e = sb_q.pop_front();
        nchecks++;
        if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0100 || bus.sel !== e.ch || bus.out_data !== e.data) begin
            nerrors++;
            $display("FAIL single_load: valid=%b ack=%b sel=%0d data=%h, required 1 0100 %0d %h",
                     bus.out_valid, bus.ack, bus.sel, bus.out_data, e.ch, e.data);
        end
        bus.req = 4'b0000;
        tick();
        nchecks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000 || bus.sel !== 2'd2 || bus.out_data !== 4'hA) begin
            nerrors++;
            $display("FAIL single_drain: valid=%b ack=%b sel=%0d data=%h, required 0 0000 2 a",
                     bus.out_valid, bus.ack, bus.sel, bus.out_data);
        end
    endtask

    // ptr is 3 after the single-channel grant of channel 2
    task automatic test_wrap();
        logic [3:0] reqs[3] = '{4'b1000, 4'b1001, 4'b1000};
        bus.a = 4'h5; bus.d = 4'h7; bus.out_ready = 1'b1;
        sb_q.push_back('{ch: 2'd3, data: 4'h7});
        sb_q.push_back('{ch: 2'd0, data: 4'h5});
        sb_q.push_back('{ch: 2'd3, data: 4'h7});
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            bus.req = reqs[k];
            tick();
            e = sb_q.pop_front();
            nchecks++;
            if (bus.out_valid !== 1'b1 || bus.ack !== (4'b0001 << e.ch) ||
                bus.sel !== e.ch || bus.out_data !== e.data) begin
                nerrors++;
                $display("FAIL wrap_grant%0d: valid=%b ack=%b sel=%0d data=%h, required ch%0d data %h",
                         k, bus.out_valid, bus.ack, bus.sel, bus.out_data, e.ch, e.data);
            end
        end
        bus.req = 4'b0000;
        tick();
        nchecks++;
        if (bus.out_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL wrap_idle: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4; bus.out_ready = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++)
            sb_q.push_back('{ch: order[k], data: 4'(order[k]) + 4'h1});
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            tick();
            e = sb_q.pop_front();
            nchecks++;
            if (bus.out_valid !== 1'b1 || bus.ack !== (4'b0001 << e.ch) ||
                bus.sel !== e.ch || bus.out_data !== e.data) begin
                nerrors++;
                $display("FAIL rr_step%0d: valid=%b ack=%b sel=%0d data=%h, required ch%0d data %h",
                         k, bus.out_valid, bus.ack, bus.sel, bus.out_data, e.ch, e.data);
            end
        end
        bus.req = 4'b0000;
        tick();
        nchecks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
            nerrors++;
            $display("FAIL rr_idle: valid=%b ack=%b, required 0 0000", bus.out_valid, bus.ack);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        bus.a = 4'h9; bus.b = 4'h6; bus.out_ready = 1'b0;
        bus.req = 4'b0011;
        sb_q.push_back('{ch: 2'd0, data: 4'h9});
        tick();
        e = sb_q.pop_front();
        nchecks++;
        if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0001 || bus.sel !== e.ch || bus.out_data !== e.data) begin
            nerrors++;
            $display("FAIL bp_first: valid=%b ack=%b sel=%0d data=%h, required 1 0001 0 9",
                     bus.out_valid, bus.ack, bus.sel, bus.out_data);
        end
        bus.req = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            tick();
            nchecks++;
            if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0000 || bus.sel !== 2'd0 || bus.out_data !== 4'h9) begin
                nerrors++;
                $display("FAIL bp_hold%0d: valid=%b ack=%b sel=%0d data=%h, required 1 0000 0 9",
                         k, bus.out_valid, bus.ack, bus.sel, bus.out_data);
            end
        end
        bus.out_ready = 1'b1;
        sb_q.push_back('{ch: 2'd1, data: 4'h6});
        tick();
        e = sb_q.pop_front();
        nchecks++;
        if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0010 || bus.sel !== e.ch || bus.out_data !== e.data) begin
            nerrors++;
            $display("FAIL bp_next: valid=%b ack=%b sel=%0d data=%h, required 1 0010 1 6",
                     bus.out_valid, bus.ack, bus.sel, bus.out_data);
        end
        bus.req = 4'b0000;
        tick();
        nchecks++;
        if (bus.out_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL bp_idle: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bus.a = 4'h3; bus.out_ready = 1'b0;
        bus.req = 4'b0001;
        sb_q.push_back('{ch: 2'd0, data: 4'h3});
        tick();
        e = sb_q.pop_front();
        nchecks++;
        if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0001 || bus.out_data !== e.data) begin
            nerrors++;
            $display("FAIL rstmid_load: valid=%b ack=%b data=%h, required 1 0001 3",
                     bus.out_valid, bus.ack, bus.out_data);
        end
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        nchecks++;
        if ({bus.ack, bus.sel, bus.out_data, bus.out_valid} !== 11'd0) begin
            nerrors++;
            $display("FAIL rstmid_clear: ack=%b sel=%0d data=%h valid=%b, required all zero",
                     bus.ack, bus.sel, bus.out_data, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{ch: 2'd0, data: 4'h3});
        tick();
        e = sb_q.pop_front();
        nchecks++;
        if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0001 || bus.sel !== e.ch || bus.out_data !== e.data) begin
            nerrors++;
            $display("FAIL rstmid_reload: valid=%b ack=%b sel=%0d data=%h, required 1 0001 0 3",
                     bus.out_valid, bus.ack, bus.sel, bus.out_data);
        end
        bus.req = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        nchecks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
            nerrors++;
            $display("FAIL rstmid_idle: valid=%b ack=%b, required 0 0000", bus.out_valid, bus.ack);
        end
    endtask

    initial begin
        nchecks = 0;
        nerrors = 0;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
